// File: rtl/mem_access_unit.sv
// Data-memory access stage: one req/ack bus cycle per load/store, with byte-lane alignment and load extension.
// Latency: MEM_REQ rises the cycle after accept; RDY pulses the cycle after MEM_ACK, or the cycle after accept on a rejected request.
// Backpressure: the bus stalls by withholding MEM_ACK (bounded by TIMEOUT); requests arriving outside IDLE are dropped.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RREQ,
  input  logic        CWE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        RDY,
  output logic [31:0] RDATA,
  output logic        FAULT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_WMASK,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;

  logic        ld_f3_ok;
  logic        st_f3_ok;
  logic        align_ok;
  logic        req_ok;
  logic [3:0]  st_mask;
  logic [31:0] st_dat;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_dat;

  assign cnt_nxt = cnt + 8'd1;

  // Classify the incoming request and pre-compute its store lanes so BUS can start on the accept edge.
  always_comb begin
    ld_f3_ok = FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3_ok = FUNCT3 inside {3'b000, 3'b001, 3'b010};
    case (FUNCT3[1:0])
      2'b01:   align_ok = ~ADDR[0];
      2'b10:   align_ok = (ADDR[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    req_ok = ~(RREQ & CWE) & (RREQ ? ld_f3_ok : st_f3_ok) & align_ok;
    case (FUNCT3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << ADDR[1:0];
        st_dat  = {4{WDATA[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << ADDR[1:0];
        st_dat  = {2{WDATA[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_dat  = WDATA;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it according to the latched access type.
  always_comb begin
    case (op_off)
      2'd0:    ld_byte = MEM_RDATA[7:0];
      2'd1:    ld_byte = MEM_RDATA[15:8];
      2'd2:    ld_byte = MEM_RDATA[23:16];
      default: ld_byte = MEM_RDATA[31:24];
    endcase
    ld_half = op_off[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    case (op_f3)
      3'b000:  ld_dat = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_dat = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_dat = {24'd0, ld_byte};
      3'b101:  ld_dat = {16'd0, ld_half};
      default: ld_dat = MEM_RDATA;
    endcase
  end

  // Transaction FSM; every output is registered and the bus fields stay frozen while in BUS.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      op_f3     <= 3'd0;
      op_off    <= 2'd0;
      RDY       <= 1'b0;
      RDATA     <= 32'd0;
      FAULT     <= 1'b0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= 32'd0;
      MEM_WMASK <= 4'd0;
      MEM_WDATA <= 32'd0;
    end else begin
      RDY   <= 1'b0;
      FAULT <= 1'b0;
      case (state)
        IDLE: begin
          if (RREQ || CWE) begin
            op_f3  <= FUNCT3;
            op_off <= ADDR[1:0];
            cnt    <= 8'd0;
            if (req_ok) begin
              state     <= BUS;
              MEM_REQ   <= 1'b1;
              MEM_WE    <= CWE;
              MEM_ADDR  <= {ADDR[31:2], 2'b00};
              MEM_WMASK <= CWE ? st_mask : 4'd0;
              MEM_WDATA <= CWE ? st_dat : 32'd0;
            end else begin
              // Rejected requests never reach the bus.
              state <= ERR;
              RDY   <= 1'b1;
              FAULT <= 1'b1;
              RDATA <= 32'd0;
            end
          end
        end
        BUS: begin
          cnt <= cnt_nxt;
          // ACK takes priority over a timeout expiring on the same edge.
          if (MEM_ACK || (cnt_nxt == TIMEOUT_CNT)) begin
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= 32'd0;
            MEM_WMASK <= 4'd0;
            MEM_WDATA <= 32'd0;
            RDY       <= 1'b1;
            if (MEM_ACK) begin
              state <= DONE;
              if (!MEM_WE) RDATA <= ld_dat;
            end else begin
              state <= ERR;
              FAULT <= 1'b1;
              RDATA <= 32'd0;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RREQ = 1'b0;
  logic        CWE = 1'b0;
  logic [2:0]  FUNCT3 = 3'd0;
  logic [31:0] ADDR = 32'd0;
  logic [31:0] WDATA = 32'd0;
  logic        RDY;
  logic [31:0] RDATA;
  logic        FAULT;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_WMASK;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  // observations from the last transaction
  int          o_req_cnt;
  int          o_rdy_at;
  int          o_rdy_cnt;
  logic        o_flt;
  logic [31:0] o_rd;
  logic        o_we;
  logic [3:0]  o_wm;
  logic [31:0] o_wd;
  logic [31:0] o_ad;
  logic        o_stable;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .RREQ(RREQ), .CWE(CWE), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .WDATA(WDATA), .RDY(RDY), .RDATA(RDATA), .FAULT(FAULT),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WMASK(MEM_WMASK), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Issue one request and act as the bus: ACK is raised during REQ cycle ack_at (0 = never).
  // Observes 12 cycles after the accept edge; iteration c sees the cycle following edge N+c-1.
  task automatic txn(input logic rr, input logic cw, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int ack_at, input logic [31:0] mrd);
    @(posedge CLK); #1;
    RREQ = rr; CWE = cw; FUNCT3 = f3; ADDR = a; WDATA = wd;
    o_req_cnt = 0; o_rdy_at = -1; o_rdy_cnt = 0; o_flt = 1'b0; o_rd = 32'd0;
    o_we = 1'b0; o_wm = 4'd0; o_wd = 32'd0; o_ad = 32'd0; o_stable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK); #1;
      RREQ = 1'b0; CWE = 1'b0;
      if (MEM_REQ) begin
        o_req_cnt++;
        if (o_req_cnt == 1) begin
          o_we = MEM_WE; o_wm = MEM_WMASK; o_wd = MEM_WDATA; o_ad = MEM_ADDR;
        end else if (MEM_WE !== o_we || MEM_WMASK !== o_wm || MEM_WDATA !== o_wd || MEM_ADDR !== o_ad) begin
          o_stable = 1'b0;
        end
      end
      if (RDY) begin
        o_rdy_cnt++;
        if (o_rdy_at < 0) begin
          o_rdy_at = c; o_flt = FAULT; o_rd = RDATA;
        end
      end
      MEM_ACK   = (c == ack_at);
      MEM_RDATA = mrd;
    end
    MEM_ACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_tests++; if (RDY !== 1'b0 || FAULT !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_fault: got %b%b want 00", RDY, FAULT); end
    n_tests++; if (RDATA !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
    n_tests++; if (MEM_REQ !== 1'b0 || MEM_WE !== 1'b0 || MEM_WMASK !== 4'd0) begin n_fail++; $display("FAIL reset_bus_ctl: got %b %b %b want 0 0 0", MEM_REQ, MEM_WE, MEM_WMASK); end
    n_tests++; if (MEM_ADDR !== 32'd0 || MEM_WDATA !== 32'd0) begin n_fail++; $display("FAIL reset_bus_dat: got %h %h want 0 0", MEM_ADDR, MEM_WDATA); end
    RST = 1'b0;
  endtask

  task automatic test_load_word();
    txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    n_tests++; if (o_ad !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", o_ad); end
    n_tests++; if (o_we !== 1'b0 || o_wm !== 4'd0) begin n_fail++; $display("FAIL lw_we_mask: got %b %b want 0 0000", o_we, o_wm); end
    n_tests++; if (o_req_cnt != 1) begin n_fail++; $display("FAIL lw_req_cycles: got %0d want 1", o_req_cnt); end
    n_tests++; if (o_rdy_at != 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", o_rdy_at); end
    n_tests++; if (o_rdy_cnt != 1) begin n_fail++; $display("FAIL lw_rdy_pulses: got %0d want 1", o_rdy_cnt); end
    n_tests++; if (o_flt !== 1'b0 || o_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got fault=%b %h want 0 deadbeef", o_flt, o_rd); end
    n_tests++; if (RDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata_hold: got %h want deadbeef", RDATA); end
  endtask

  task automatic test_load_extend();
    txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0011);
    n_tests++; if (o_rd !== 32'hFFFFFF80 || o_ad !== 32'h100) begin n_fail++; $display("FAIL lb_sext: got %h @%h want ffffff80 @00000100", o_rd, o_ad); end
    txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0011);
    n_tests++; if (o_rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000080", o_rd); end
    txn(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 2, 32'h80FF0011);
    n_tests++; if (o_rd !== 32'hFFFF80FF || o_rdy_at != 3) begin n_fail++; $display("FAIL lh_sext: got %h at %0d want ffff80ff at 3", o_rd, o_rdy_at); end
    txn(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80FF0011);
    n_tests++; if (o_rd !== 32'h000080FF) begin n_fail++; $display("FAIL lhu_zext: got %h want 000080ff", o_rd); end
    txn(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h80FF0011);
    n_tests++; if (o_rd !== 32'h00000000) begin n_fail++; $display("FAIL lb_lane1: got %h want 00000000", o_rd); end
    txn(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 1, 32'h80FF0011);
    n_tests++; if (o_rd !== 32'h00000011) begin n_fail++; $display("FAIL lb_lane0: got %h want 00000011", o_rd); end
  endtask

  task automatic test_store();
    txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 4, 32'hFFFFFFFF);
    n_tests++; if (o_we !== 1'b1 || o_wm !== 4'b0010) begin n_fail++; $display("FAIL sb_we_mask: got %b %b want 1 0010", o_we, o_wm); end
    n_tests++; if (o_wd !== 32'h78787878 || o_ad !== 32'h200) begin n_fail++; $display("FAIL sb_data_addr: got %h @%h want 78787878 @00000200", o_wd, o_ad); end
    n_tests++; if (o_req_cnt != 4 || !o_stable) begin n_fail++; $display("FAIL sb_req_hold: got %0d cycles stable=%b want 4 stable=1", o_req_cnt, o_stable); end
    n_tests++; if (o_rdy_at != 5 || o_flt !== 1'b0) begin n_fail++; $display("FAIL sb_done: got at %0d fault=%b want at 5 fault=0", o_rdy_at, o_flt); end
    n_tests++; if (o_rd !== 32'h00000011) begin n_fail++; $display("FAIL sb_rdata_kept: got %h want 00000011", o_rd); end
    txn(1'b0, 1'b1, 3'b001, 32'h202, 32'hAABBCCDD, 1, 32'h0);
    n_tests++; if (o_wm !== 4'b1100 || o_wd !== 32'hCCDDCCDD) begin n_fail++; $display("FAIL sh_lanes: got %b %h want 1100 ccddccdd", o_wm, o_wd); end
    txn(1'b0, 1'b1, 3'b010, 32'h204, 32'hAABBCCDD, 1, 32'h0);
    n_tests++; if (o_wm !== 4'b1111 || o_wd !== 32'hAABBCCDD || o_ad !== 32'h204) begin n_fail++; $display("FAIL sw_lanes: got %b %h @%h want 1111 aabbccdd @00000204", o_wm, o_wd, o_ad); end
  endtask

  task automatic test_invalid();
    txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h55555555);
    n_tests++; if (o_req_cnt != 0 || o_rdy_at != 1 || o_flt !== 1'b1 || o_rd !== 32'd0) begin n_fail++; $display("FAIL lw_misaligned: got req=%0d at=%0d fault=%b %h want 0 1 1 0", o_req_cnt, o_rdy_at, o_flt, o_rd); end
    txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h0BADF00D);
    n_tests++; if (o_rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL reload: got %h want 0badf00d", o_rd); end
    txn(1'b0, 1'b1, 3'b001, 32'h001, 32'h1234, 1, 32'h0);
    n_tests++; if (o_req_cnt != 0 || o_rdy_at != 1 || o_flt !== 1'b1 || o_rd !== 32'd0) begin n_fail++; $display("FAIL sh_misaligned: got req=%0d at=%0d fault=%b %h want 0 1 1 0", o_req_cnt, o_rdy_at, o_flt, o_rd); end
    txn(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 1, 32'h0);
    n_tests++; if (o_req_cnt != 0 || o_rdy_at != 1 || o_flt !== 1'b1) begin n_fail++; $display("FAIL rreq_cwe_both: got req=%0d at=%0d fault=%b want 0 1 1", o_req_cnt, o_rdy_at, o_flt); end
    txn(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
    n_tests++; if (o_req_cnt != 0 || o_flt !== 1'b1) begin n_fail++; $display("FAIL load_bad_f3: got req=%0d fault=%b want 0 1", o_req_cnt, o_flt); end
    txn(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 1, 32'h0);
    n_tests++; if (o_req_cnt != 0 || o_flt !== 1'b1) begin n_fail++; $display("FAIL store_bad_f3: got req=%0d fault=%b want 0 1", o_req_cnt, o_flt); end
  endtask

  task automatic test_timeout();
    txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 32'h77777777);
    txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
    n_tests++; if (o_req_cnt != 4 || o_rdy_at != 5) begin n_fail++; $display("FAIL timeout_cycles: got req=%0d at=%0d want 4 5", o_req_cnt, o_rdy_at); end
    n_tests++; if (o_flt !== 1'b1 || o_rd !== 32'd0 || o_rdy_cnt != 1) begin n_fail++; $display("FAIL timeout_fault: got fault=%b %h pulses=%0d want 1 0 1", o_flt, o_rd, o_rdy_cnt); end
    txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 4, 32'h11223344);
    n_tests++; if (o_req_cnt != 4 || o_rdy_at != 5 || o_flt !== 1'b0 || o_rd !== 32'h11223344) begin n_fail++; $display("FAIL ack_at_limit: got req=%0d at=%0d fault=%b %h want 4 5 0 11223344", o_req_cnt, o_rdy_at, o_flt, o_rd); end
  endtask

  task automatic test_ack_outside_bus();
    logic seen;
    seen = 1'b0;
    @(posedge CLK); #1;
    MEM_ACK = 1'b1; MEM_RDATA = 32'hABCDABCD;
    repeat (3) begin
      @(posedge CLK); #1;
      if (RDY || MEM_REQ) seen = 1'b1;
    end
    MEM_ACK = 1'b0;
    n_tests++; if (seen !== 1'b0 || RDATA !== 32'h11223344) begin n_fail++; $display("FAIL idle_ack: got activity=%b %h want 0 11223344", seen, RDATA); end
  endtask

  task automatic test_reset_mid_bus();
    logic seen;
    @(posedge CLK); #1;
    RREQ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h400; MEM_ACK = 1'b0;
    @(posedge CLK); #1;
    RREQ = 1'b0;
    n_tests++; if (MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b want 1", MEM_REQ); end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_tests++; if (MEM_REQ !== 1'b0 || RDY !== 1'b0 || RDATA !== 32'd0) begin n_fail++; $display("FAIL rst_abort: got req=%b rdy=%b %h want 0 0 0", MEM_REQ, RDY, RDATA); end
    seen = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (RDY || MEM_REQ) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_rdy: got activity=%b want 0", seen); end
    txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 2, 32'hCAFEF00D);
    n_tests++; if (o_rdy_at != 3 || o_flt !== 1'b0 || o_rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL post_rst_lw: got at=%0d fault=%b %h want 3 0 cafef00d", o_rdy_at, o_flt, o_rd); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_invalid();
    test_timeout();
    test_ack_outside_bus();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
